hd_pack: RTL and testbench
==========================

HD_PACK -- requirements
Module: hd_pack

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of one input word; output is 2*DATA_WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream word available on in_data.
REQ-005 in_ready  output  1  hd_pack can accept a word this cycle.
REQ-006 in_data  input  DATA_WIDTH  upstream word.
REQ-007 in_last  input  1  qualifies in_data as final word of a burst; meaningful only with in_valid.
REQ-008 out_valid  output  1  packed word available on out_data.
REQ-009 out_ready  input  1  downstream accepts the packed word.
REQ-010 out_data  output  2*DATA_WIDTH  packed word: [DATA_WIDTH-1:0] = first word, [2*DATA_WIDTH-1:DATA_WIDTH] = second word.
REQ-011 out_half  output  1  high when only the low half of out_data holds valid data (odd-length burst tail).

Function
REQ-012 Input transfer occurs on a rising edge where in_valid && in_ready; output transfer on a rising edge where out_valid && out_ready.
REQ-013 State machine SHALL have three states: EMPTY (nothing held), HALF (low half held, output not valid), FULL (out_valid=1).
REQ-014 in_ready SHALL be combinational: 1 in EMPTY or HALF; equals out_ready in FULL; 0 while rst is asserted.
REQ-015 EMPTY, input transfer with in_last=0: capture word into low half -> HALF.
REQ-016 EMPTY, input transfer with in_last=1: low half = word, high half = 0, out_half=1 -> FULL.
REQ-017 HALF, input transfer (any in_last): high half = word, out_half=0 -> FULL.
REQ-018 HALF with no input transfer: hold; no timeout, no spontaneous flush.
REQ-019 FULL, output transfer without input transfer: -> EMPTY; out_valid=0 next cycle.
REQ-020 FULL, simultaneous output and input transfer: old packed word leaves; new word handled as in REQ-015/REQ-016 (-> HALF, or -> FULL with out_half=1); no bubble.
REQ-021 FULL without output transfer: out_data, out_half, out_valid SHALL hold stable regardless of in_valid/in_data.
REQ-022 Latency: out_valid rises in the cycle immediately after the edge accepting the second word (or an in_last word from EMPTY); no combinational path from in_data to out_data.
REQ-023 out_valid SHALL never deassert without an output transfer.
REQ-024 No data dropped or duplicated: every accepted word appears exactly once in out_data, in order.
REQ-025 Sustained throughput with in_valid=out_ready=1: one packed word per two clock cycles.
REQ-026 in_data/in_last ignored when in_valid=0; out_ready ignored when out_valid=0.

Reset
REQ-027 On rst assertion, immediately (asynchronously): state=EMPTY, out_valid=0, out_half=0, out_data=0, in_ready=0.
REQ-028 After rst deasserts, in_ready=1 in the same cycle; first transfer possible on the next rising edge.
REQ-029 Reset mid-operation (HALF or FULL) discards the held half/packed word; it SHALL NOT appear after reset.

Verification
REQ-030 Pair: reset, then in_data=0x0001 then 0x0002 on consecutive edges, out_ready=1 -> out_valid=1 one cycle after second accept, out_data=0x0002_0001, out_half=0, one-cycle pulse.
REQ-031 Backpressure: packed 0x0004_0003 with out_ready=0 for 4 cycles while in_valid=1 and in_data=0x0005 -> out_data held, in_ready=0, no accept; on out_ready=1, 0x0005 accepted same edge, state HALF.
REQ-032 Odd tail: 0x00AA with in_last=1 from EMPTY -> out_data=0x0000_00AA, out_half=1; in_last on second word -> out_half=0.
REQ-033 Streaming: in_valid=out_ready=1, in_data incrementing from 1 for 8 words -> 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007 in order, every second cycle.
REQ-034 Reset mid-op: accept 0x0011, assert rst for one cycle, then send 0x0022, 0x0033 -> out_data=0x0033_0022; 0x0011 never output.
REQ-035 Idle gaps: in_valid toggled 1/0 with gaps between words, out_ready random -> scoreboard confirms REQ-024 and REQ-021 for 200 words.

Source files
------------

// File: rtl/hd_pack.sv
// Packs pairs of DATA_WIDTH words into one 2*DATA_WIDTH word.
// A burst with an odd word count ends in a half-filled word flagged by out_half.
module hd_pack #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_half
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  half;
  } pack_t;

  state_t state, state_nxt;
  pack_t  pk, pk_nxt;
  logic   in_xfer, out_xfer, load_first;

  // FULL only frees up when the held word leaves on the same edge.
  assign in_ready  = !rst && ((state != FULL) || out_ready);
  assign out_valid = (state == FULL);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = {pk.hi, pk.lo};
  assign out_half  = pk.half;

  // A word lands in the low half from EMPTY, or from FULL as the old word drains.
  assign load_first = in_xfer && ((state == EMPTY) || ((state == FULL) && out_xfer));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      pk    <= '0;
    end else begin
      state <= state_nxt;
      pk    <= pk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pk_nxt    = pk;
    case (state)
      EMPTY: ;
      HALF: begin
        if (in_xfer) begin
          pk_nxt.hi   = in_data;
          pk_nxt.half = 1'b0;
          state_nxt   = FULL;
        end
      end
      FULL: begin
        if (out_xfer) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (load_first) begin
      pk_nxt.lo = in_data;
      if (in_last) begin
        pk_nxt.hi   = '0;
        pk_nxt.half = 1'b1;
        state_nxt   = FULL;
      end else begin
        pk_nxt.half = 1'b0;
        state_nxt   = HALF;
      end
    end
  end

endmodule

// File: tb/tb_hd_pack.sv
// Bench for hd_pack: cycle vector table, reset corner sequences and a
// randomized run checked against a packing scoreboard.
module tb_hd_pack;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, out_valid, out_half;
  logic [2*DW-1:0] out_data;

  int errors = 0;
  int checks = 0;

  hd_pack #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_half(out_half)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          l;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [31:0]   e_od;
    logic          e_oh;
  } vec_t;

  vec_t tv[$];

  // scoreboard state: expected {half, packed word}, pending low word
  logic [2*DW:0] sbq[$];
  logic          have_lo = 1'b0;
  logic [DW-1:0] lo_word = '0;
  int            acc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic l, logic ordy,
                              logic e_irdy, logic e_ov, logic [31:0] e_od, logic e_oh);
    vec_t v;
    v.iv = iv; v.d = d; v.l = l; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_oh = e_oh;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic l, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_data = d; in_last = l; out_ready = ordy;
    #1;
  endtask

  task automatic model_step();
    logic m_full, e_rdy;
    m_full = (sbq.size() != 0);
    e_rdy  = !m_full || out_ready;
    chk("sb_ready", in_ready, e_rdy);
    chk("sb_valid", out_valid, m_full);
    if (m_full) chk("sb_data", {out_half, out_data}, sbq[0]);
    if (m_full && out_ready) void'(sbq.pop_front());
    if (in_valid && e_rdy) begin
      acc++;
      if (have_lo) begin
        sbq.push_back({1'b0, in_data, lo_word});
        have_lo = 1'b0;
      end else if (in_last) begin
        sbq.push_back({1'b1, {DW{1'b0}}, in_data});
      end else begin
        lo_word = in_data;
        have_lo = 1'b1;
      end
    end
  endtask

  initial begin
    int cyc;
    // pair, backpressure, odd tail, streaming, ignored idle inputs
    tv.push_back(mk(1, 16'h0001, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0002, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 32'h0002_0001, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0003, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0004, 0, 0, 1, 0, 32'h0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1, 16'h0005, 0, 0, 0, 1, 32'h0004_0003, 0));
    tv.push_back(mk(1, 16'h0005, 0, 1, 1, 1, 32'h0004_0003, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0006, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 32'h0006_0005, 0));
    tv.push_back(mk(1, 16'h00AA, 1, 0, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 32'h0000_00AA, 1));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 32'h0000_00AA, 1));
    tv.push_back(mk(1, 16'h00BB, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h00CC, 1, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 32'h00CC_00BB, 0));
    tv.push_back(mk(1, 16'h0001, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0002, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0003, 0, 1, 1, 1, 32'h0002_0001, 0));
    tv.push_back(mk(1, 16'h0004, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0005, 0, 1, 1, 1, 32'h0004_0003, 0));
    tv.push_back(mk(1, 16'h0006, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(1, 16'h0007, 0, 1, 1, 1, 32'h0006_0005, 0));
    tv.push_back(mk(1, 16'h0008, 0, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 32'h0008_0007, 0));
    tv.push_back(mk(0, 16'h1234, 1, 1, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 32'h0, 0));

    // reset state, with handshake inputs active
    out_ready = 1'b1; in_valid = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_half", out_half, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_release_rdy", in_ready, 1'b1);

    foreach (tv[i]) begin
      drive(tv[i].iv, tv[i].d, tv[i].l, tv[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tv[i].e_irdy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tv[i].e_ov);
      if (tv[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, tv[i].e_od);
        chk($sformatf("vec%0d_out_half", i), out_half, tv[i].e_oh);
      end
    end

    // reset while HALF drops the held word
    drive(1, 16'h0011, 0, 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 16'h0022, 0, 1);
    chk("midrst_ov0", out_valid, 1'b0);
    drive(1, 16'h0033, 0, 1);
    chk("midrst_ov1", out_valid, 1'b0);
    drive(0, 16'h0000, 0, 1);
    chk("midrst_ov2", out_valid, 1'b1);
    chk("midrst_data", out_data, 32'h0033_0022);
    chk("midrst_half", out_half, 1'b0);

    // asynchronous reset while FULL clears outputs before any edge
    drive(1, 16'h0044, 1, 0);
    drive(0, 16'h0000, 0, 0);
    chk("full_pre_data", {out_half, out_data}, {1'b1, 32'h0000_0044});
    #1 rst = 1'b1;
    #1;
    chk("async_ov", out_valid, 1'b0);
    chk("async_od", out_data, 32'h0);
    chk("async_oh", out_half, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 16'h0000, 0, 1);
    chk("async_no_replay", out_valid, 1'b0);

    // random gaps and backpressure against the scoreboard
    cyc = 0;
    while (acc < 200 && cyc < 5000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      in_last   = (acc == 199) ? 1'b1 : ($urandom_range(0, 3) == 0);
      out_ready = $urandom_range(0, 1) != 0;
      #1;
      model_step();
      cyc++;
    end
    chk("sb_words_accepted", acc, 200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      model_step();
    end
    chk("sb_drained", {have_lo, 31'(sbq.size())}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
